// File: rtl/spi_arb.sv
// -----------------------------------------------------------------------------
// spi_arb
//
// Shares one SPI_mnrch master between two requesters (the inertial sensor
// sequencer and a second client such as an A2D/battery monitor). Each
// requester drops a 16-bit command into its own 1-deep buffer. The arbiter
// grants the bus round-robin, pulses wrt to SPI_mnrch, waits for done or a
// timeout, holds off for an inter-transaction gap, and hands the read data
// back to whichever requester owned the transfer.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req0/cmd0         requester 0 command strobe and 16-bit command
//   busy0             requester 0 buffer occupied
//   done0             1-clock pulse, requester 0 transfer finished
//   req1/cmd1/busy1/done1   same for requester 1
//   rd_data           read data of the most recent completed transfer
//   tmo               1-clock pulse with doneN when that transfer timed out
//   spi_wrt/spi_cmd   wrt strobe and wt_data to SPI_mnrch
//   spi_done          done from SPI_mnrch
//   spi_rd_data       rd_data from SPI_mnrch
//
// Parameters:
//   GAP_CYC   idle clocks between end of a transfer and the next launch
//   TIMEOUT   clocks in XFER without spi_done before the transfer is aborted
// -----------------------------------------------------------------------------
module spi_arb #(
   parameter int GAP_CYC = 16,
   parameter int TIMEOUT = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [15:0] cmd0,
   output logic        busy0,
   output logic        done0,
   input  logic        req1,
   input  logic [15:0] cmd1,
   output logic        busy1,
   output logic        done1,
   output logic [15:0] rd_data,
   output logic        tmo,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data
);

   // One counter serves both the XFER timeout and the GAP hold-off; the two
   // phases never overlap.
   localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      XFER,
      GAP
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [15:0]      r_buf0;
   logic [15:0]      r_buf1;
   logic             r_pend0;
   logic             r_pend1;
   // Owner of the current transfer; between transfers it is the last grant,
   // which is what the tie-break looks at. Resets to 1 so requester 0 wins
   // the first tie.
   logic             r_gnt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done0;
   logic             r_done1;
   logic             r_tmo;
   logic [15:0]      r_rd_data;

   logic             w_gnt_nxt;
   logic             w_fin;        // transfer ends at this edge
   logic             w_timed_out;  // ...and it ended by timeout
   logic [15:0]      w_buf_sel;

   assign w_buf_sel = r_gnt ? r_buf1 : r_buf0;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         // NOTE: registers are written with <= so every flop samples the
         // pre-edge values; a blocking = here would race other always_ff.
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and bus outputs
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case leaves one unassigned (that would infer a latch).
      w_next      = r_state;
      w_gnt_nxt   = r_gnt;
      w_fin       = 1'b0;
      w_timed_out = 1'b0;
      spi_wrt     = 1'b0;
      spi_cmd     = '0;

      case (r_state)
         IDLE: begin
            if (r_pend0 && r_pend1) begin
               w_gnt_nxt = ~r_gnt;
               w_next    = LAUNCH;
            end else if (r_pend0) begin
               w_gnt_nxt = 1'b0;
               w_next    = LAUNCH;
            end else if (r_pend1) begin
               w_gnt_nxt = 1'b1;
               w_next    = LAUNCH;
            end
         end

         LAUNCH: begin
            spi_wrt = 1'b1;
            spi_cmd = w_buf_sel;
            w_next  = XFER;
         end

         XFER: begin
            spi_cmd = w_buf_sel;
            // spi_done wins over a coincident timeout.
            if (spi_done) begin
               w_fin = 1'b1;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_fin       = 1'b1;
               w_timed_out = 1'b1;
            end
            if (w_fin) begin
               w_next = (GAP_CYC == 0) ? IDLE : GAP;
            end
         end

         GAP: begin
            if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
               w_next = IDLE;
            end
         end

         default: w_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Command buffers
   // ---------------------------------------------------------------------
   // NOTE: the data buffers carry no reset; r_pendN alone says whether the
   // contents are meaningful, so reset only has to clear the pend flags.
   always_ff @(posedge clk) begin
      if (req0 && !r_pend0) r_buf0 <= cmd0;
      if (req1 && !r_pend1) r_buf1 <= cmd1;
   end

   // ---------------------------------------------------------------------
   // Pend flags, grant, counter, completion outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend0   <= 1'b0;
         r_pend1   <= 1'b0;
         r_gnt     <= 1'b1;
         r_cnt     <= '0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_tmo     <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_tmo   <= 1'b0;
         r_gnt   <= w_gnt_nxt;

         // A pend flag being cleared belongs to the owner, whose busy is high,
         // so capture and clear never hit the same flag on one edge.
         if (req0 && !r_pend0) r_pend0 <= 1'b1;
         if (req1 && !r_pend1) r_pend1 <= 1'b1;

         case (r_state)
            XFER:    r_cnt <= w_fin ? '0 : r_cnt + CNT_W'(1);
            GAP:     r_cnt <= r_cnt + CNT_W'(1);
            default: r_cnt <= '0;
         endcase

         if (w_fin) begin
            r_tmo <= w_timed_out;
            if (!w_timed_out) r_rd_data <= spi_rd_data;
            if (r_gnt) begin
               r_done1 <= 1'b1;
               r_pend1 <= 1'b0;
            end else begin
               r_done0 <= 1'b1;
               r_pend0 <= 1'b0;
            end
         end
      end
   end

   assign busy0   = r_pend0;
   assign busy1   = r_pend1;
   assign done0   = r_done0;
   assign done1   = r_done1;
   assign tmo     = r_tmo;
   assign rd_data = r_rd_data;

endmodule

// File: tb/tb_spi_arb.sv
// -----------------------------------------------------------------------------
// tb_spi_arb
//
// Self-checking bench for spi_arb. A cycle-indexed model (pending flags,
// buffers, launch cycle of the active transfer, first cycle a new grant may
// be made) predicts every output each cycle; a directed sequence adds
// hand-computed expectations for the single request, round-robin ties,
// busy drop, timeout, done/timeout collision, spurious done and reset.
// -----------------------------------------------------------------------------
module tb_spi_arb;

   localparam int GAP_CYC = 16;
   localparam int TIMEOUT = 2048;

   logic        clk;
   logic        rst;
   logic        req0;
   logic [15:0] cmd0;
   logic        busy0;
   logic        done0;
   logic        req1;
   logic [15:0] cmd1;
   logic        busy1;
   logic        done1;
   logic [15:0] rd_data;
   logic        tmo;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rd_data;

   int n_vec = 0;
   int n_err = 0;

   spi_arb #(
      .GAP_CYC(GAP_CYC),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .cmd0       (cmd0),
      .busy0      (busy0),
      .done0      (done0),
      .req1       (req1),
      .cmd1       (cmd1),
      .busy1      (busy1),
      .done1      (done1),
      .rd_data    (rd_data),
      .tmo        (tmo),
      .spi_wrt    (spi_wrt),
      .spi_cmd    (spi_cmd),
      .spi_done   (spi_done),
      .spi_rd_data(spi_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance n rising edges and settle just after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a spi_wrt pulse; n = cycles waited, -1 if none came.
   task automatic wait_wrt(input int limit, output int n);
      n = 0;
      while (spi_wrt !== 1'b1 && n < limit) begin
         tick(1);
         n++;
      end
      if (spi_wrt !== 1'b1) n = -1;
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: time-indexed view of the arbiter
   // ---------------------------------------------------------------------
   int          cyc = 0;
   bit          m_valid = 1'b0;
   logic [1:0]  m_pend;
   logic [15:0] m_buf [2];
   bit          m_active;     // a transfer is between launch and its end
   int          m_launch;     // cycle in which wrt is pulsed
   bit          m_owner;
   bit          m_last;
   int          m_free;       // first cycle in which a grant may be made
   logic [1:0]  e_done;
   bit          e_tmo;
   logic [15:0] e_rd;

   always @(negedge clk) begin
      logic [1:0]  old_p;
      logic [15:0] exp_cmd;
      bit          exp_wrt;

      if (m_valid) begin
         exp_wrt = m_active && (cyc == m_launch);
         exp_cmd = m_active ? m_buf[m_owner] : 16'h0000;
         check("m_busy0",   32'(busy0),   32'(m_pend[0]));
         check("m_busy1",   32'(busy1),   32'(m_pend[1]));
         check("m_done0",   32'(done0),   32'(e_done[0]));
         check("m_done1",   32'(done1),   32'(e_done[1]));
         check("m_tmo",     32'(tmo),     32'(e_tmo));
         check("m_rd_data", 32'(rd_data), 32'(e_rd));
         check("m_spi_wrt", 32'(spi_wrt), 32'(exp_wrt));
         check("m_spi_cmd", 32'(spi_cmd), 32'(exp_cmd));
      end

      // Effect of the coming rising edge.
      if (rst) begin
         m_valid  = 1'b1;
         m_pend   = 2'b00;
         m_active = 1'b0;
         m_last   = 1'b1;
         m_free   = cyc + 1;
         e_done   = 2'b00;
         e_tmo    = 1'b0;
         e_rd     = 16'h0000;
      end else if (m_valid) begin
         old_p  = m_pend;
         e_done = 2'b00;
         e_tmo  = 1'b0;
         if (req0 && !old_p[0]) begin
            m_pend[0] = 1'b1;
            m_buf[0]  = cmd0;
         end
         if (req1 && !old_p[1]) begin
            m_pend[1] = 1'b1;
            m_buf[1]  = cmd1;
         end
         if (m_active && cyc > m_launch && (spi_done || cyc == m_launch + TIMEOUT)) begin
            e_done[m_owner] = 1'b1;
            e_tmo           = !spi_done;
            if (spi_done) e_rd = spi_rd_data;
            m_pend[m_owner] = 1'b0;
            m_active        = 1'b0;
            m_free          = cyc + 1 + GAP_CYC;
         end else if (!m_active && cyc >= m_free && old_p != 2'b00) begin
            m_owner  = (old_p == 2'b11) ? !m_last : old_p[1];
            m_last   = m_owner;
            m_active = 1'b1;
            m_launch = cyc + 1;
         end
      end
      cyc++;
   end

   // ---------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ---------------------------------------------------------------------
   task automatic finish_xfer(input int wait_cyc, input logic [15:0] rd);
      tick(wait_cyc);
      spi_done    = 1'b1;
      spi_rd_data = rd;
      tick(1);
      spi_done    = 1'b0;
      spi_rd_data = 16'h0000;
   endtask

   initial begin
      int n;
      int wrt_cnt;
      int done_cnt;

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0;
      spi_done = 1'b0; spi_rd_data = '0;
      tick(3);
      rst = 1'b0;

      // Reset state
      check("rst_busy0",   32'(busy0),   0);
      check("rst_busy1",   32'(busy1),   0);
      check("rst_spi_wrt", 32'(spi_wrt), 0);
      check("rst_spi_cmd", 32'(spi_cmd), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_tmo",     32'(tmo),     0);

      // Single request
      req0 = 1'b1; cmd0 = 16'hA200;
      tick(1);
      req0 = 1'b0; cmd0 = '0;
      check("t1_busy0", 32'(busy0), 1);
      tick(1);
      check("t1_wrt", 32'(spi_wrt), 1);
      check("t1_cmd", 32'(spi_cmd), 'hA200);
      tick(1);
      check("t1_wrt_once", 32'(spi_wrt), 0);
      check("t1_cmd_xfer", 32'(spi_cmd), 'hA200);
      finish_xfer(38, 16'h00C3);
      check("t1_done0", 32'(done0),   1);
      check("t1_rd",    32'(rd_data), 'h00C3);
      check("t1_busy0", 32'(busy0),   0);
      check("t1_tmo",   32'(tmo),     0);
      tick(1);
      check("t1_done0_pulse", 32'(done0), 0);
      tick(20);

      // Simultaneous requests from reset: 0 then 1
      rst = 1'b1; tick(1); rst = 1'b0;
      req0 = 1'b1; cmd0 = 16'hA300; req1 = 1'b1; cmd1 = 16'h8000;
      tick(1);
      req0 = 1'b0; req1 = 1'b0;
      tick(1);
      check("t2_wrt_a", 32'(spi_wrt), 1);
      check("t2_cmd_a", 32'(spi_cmd), 'hA300);
      finish_xfer(5, 16'h1234);
      check("t2_done0", 32'(done0), 1);
      check("t2_done1", 32'(done1), 0);
      wait_wrt(40, n);
      check("t2_gap",   n, 17);
      check("t2_cmd_b", 32'(spi_cmd), 'h8000);
      finish_xfer(3, 16'h2345);
      check("t2_done1_b", 32'(done1), 1);
      tick(20);

      // Lone requester 0 so the last grant is 0
      req0 = 1'b1; cmd0 = 16'h0A0A;
      tick(1);
      req0 = 1'b0;
      tick(1);
      check("t2_cmd_solo", 32'(spi_cmd), 'h0A0A);
      finish_xfer(3, 16'h3456);
      check("t2_done0_solo", 32'(done0), 1);
      tick(20);

      // Tie again: requester 1 goes first now
      req0 = 1'b1; cmd0 = 16'hA301; req1 = 1'b1; cmd1 = 16'h8001;
      tick(1);
      req0 = 1'b0; req1 = 1'b0;
      tick(1);
      check("t2_cmd_tie1", 32'(spi_cmd), 'h8001);
      finish_xfer(3, 16'h4567);
      check("t2_done1_tie", 32'(done1), 1);
      wait_wrt(40, n);
      check("t2_gap2",     n, 17);
      check("t2_cmd_tie0", 32'(spi_cmd), 'hA301);
      finish_xfer(3, 16'h5678);
      check("t2_done0_tie", 32'(done0), 1);
      tick(20);

      // Busy drop: second req0 while busy is ignored
      req0 = 1'b1; cmd0 = 16'h2222;
      tick(1);
      cmd0 = 16'h1111;
      check("t3_busy0", 32'(busy0), 1);
      tick(1);
      req0 = 1'b0;
      check("t3_cmd", 32'(spi_cmd), 'h2222);
      finish_xfer(3, 16'h0F0F);
      check("t3_done0", 32'(done0), 1);
      wrt_cnt  = 0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (spi_wrt === 1'b1) wrt_cnt++;
         if (done0 === 1'b1) done_cnt++;
      end
      check("t3_no_relaunch", wrt_cnt,  0);
      check("t3_one_done",    done_cnt, 0);

      // Timeout with requester 1 waiting
      req0 = 1'b1; cmd0 = 16'h3333;
      tick(1);
      req0 = 1'b0; req1 = 1'b1; cmd1 = 16'h4444;
      tick(1);
      req1 = 1'b0;
      check("t4_wrt", 32'(spi_wrt), 1);
      check("t4_cmd", 32'(spi_cmd), 'h3333);
      tick(TIMEOUT);
      check("t4_no_early_done", 32'(done0), 0);
      tick(1);
      check("t4_done0", 32'(done0),   1);
      check("t4_tmo",   32'(tmo),     1);
      check("t4_rd",    32'(rd_data), 'h0F0F);
      check("t4_busy0", 32'(busy0),   0);
      wait_wrt(40, n);
      check("t4_next_gap", n, 17);
      check("t4_next_cmd", 32'(spi_cmd), 'h4444);
      finish_xfer(2, 16'h5555);
      check("t4_done1", 32'(done1),   1);
      check("t4_tmo1",  32'(tmo),     0);
      check("t4_rd1",   32'(rd_data), 'h5555);
      tick(20);

      // spi_done on the timeout cycle counts as completion
      req1 = 1'b1; cmd1 = 16'h6666;
      tick(1);
      req1 = 1'b0;
      tick(1);
      check("t5_wrt", 32'(spi_wrt), 1);
      finish_xfer(TIMEOUT, 16'h7777);
      check("t5_done1", 32'(done1),   1);
      check("t5_tmo",   32'(tmo),     0);
      check("t5_rd",    32'(rd_data), 'h7777);
      tick(20);

      // Spurious spi_done while idle
      spi_done = 1'b1; spi_rd_data = 16'hDEAD;
      tick(3);
      spi_done = 1'b0; spi_rd_data = '0;
      check("t6_done0", 32'(done0),   0);
      check("t6_done1", 32'(done1),   0);
      check("t6_rd",    32'(rd_data), 'h7777);
      tick(2);

      // Reset during XFER
      req0 = 1'b1; cmd0 = 16'h8888;
      tick(1);
      req0 = 1'b0; req1 = 1'b1; cmd1 = 16'h9999;
      tick(1);
      req1 = 1'b0;
      check("t7_wrt", 32'(spi_wrt), 1);
      tick(5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t7_busy0", 32'(busy0),   0);
      check("t7_busy1", 32'(busy1),   0);
      check("t7_wrt0",  32'(spi_wrt), 0);
      check("t7_cmd0",  32'(spi_cmd), 0);
      check("t7_done0", 32'(done0),   0);
      check("t7_done1", 32'(done1),   0);
      tick(3);
      check("t7_idle_wrt", 32'(spi_wrt), 0);
      req1 = 1'b1; cmd1 = 16'hABCD;
      tick(1);
      req1 = 1'b0;
      tick(1);
      check("t7_wrt_new", 32'(spi_wrt), 1);
      check("t7_cmd_new", 32'(spi_cmd), 'hABCD);
      finish_xfer(4, 16'h4321);
      check("t7_done1_new", 32'(done1),   1);
      check("t7_rd_new",    32'(rd_data), 'h4321);
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
